// File: rtl/fb_pkg.sv
// fb_pkg: framebuffer geometry, widths and arbiter state type shared by the
// scan-out timing block and the framebuffer port arbiter.
package fb_pkg;
   localparam int FB_ADDR_W = 19;
   localparam int FB_DATA_W = 12;
   localparam int H_ACTIVE  = 640;
   localparam int V_ACTIVE  = 480;
   typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} arb_state_t;
endpackage

// File: rtl/fb_rr_pick2.sv
// fb_rr_pick2: 2-way round-robin picker with burst lock, one-hot grant.
module fb_rr_pick2 (
   input  logic [1:0] req_i,
   input  logic       rr_ptr_i,
   input  logic       lock_i,
   input  logic       lock_id_i,
   output logic [1:0] gnt_o
);
   logic [1:0] lock_oh, rr_oh;
   assign lock_oh = lock_id_i ? 2'b10 : 2'b01;
   assign rr_oh   = rr_ptr_i ? 2'b10 : 2'b01;
   assign gnt_o   = lock_i ? (req_i & lock_oh) : (&req_i ? rr_oh : req_i);
endmodule

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: shares one framebuffer BRAM port between scan-out reads
// (absolute priority) and two round-robin UI writers; FB_ARB_STATS_EN adds counters.
module fb_port_arbiter
   import fb_pkg::*;
#(
   parameter int ADDR_W    = FB_ADDR_W,
   parameter int DATA_W    = FB_DATA_W,
   parameter int RD_LAT    = 1,
   parameter int BURST_MAX = 16
) (
   input  logic              clk_vga,
   input  logic              rst_n,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic [DATA_W-1:0] vid_rdata,
   output logic              vid_valid,
   input  logic [1:0]        wr_req,
   input  logic [ADDR_W-1:0] wr_addr0,
   input  logic [ADDR_W-1:0] wr_addr1,
   input  logic [DATA_W-1:0] wr_data0,
   input  logic [DATA_W-1:0] wr_data1,
   input  logic [1:0]        wr_last,
   output logic [1:0]        wr_gnt,
   output logic [ADDR_W-1:0] fb_addr,
   output logic              fb_we,
   output logic [DATA_W-1:0] fb_wdata,
   input  logic [DATA_W-1:0] fb_rdata
`ifdef FB_ARB_STATS_EN
   ,
   output logic [31:0]       stat_wr_cnt,
   output logic [31:0]       stat_stall_cnt
`endif
);
   arb_state_t        state_q, state_d;
   logic              rr_q, rr_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              we_q;
   logic [RD_LAT:0]   vid_pipe_q;
   logic [1:0]        pick, xfer;
   logic              any_x, wn, last;
   fb_rr_pick2 u_pick (
      .req_i     (wr_req),
      .rr_ptr_i  (rr_q),
      .lock_i    (state_q != IDLE),
      .lock_id_i (state_q == LOCK1),
      .gnt_o     (pick)
   );
   // Grant is gated by reset too, so it drops immediately with rst_n.
   assign wr_gnt    = (rst_n && !vid_req) ? pick : 2'b00;
   assign xfer      = wr_req & wr_gnt;
   assign any_x     = |xfer;
   assign wn        = xfer[1];
   assign last      = wr_last[wn];
   assign addr_d    = any_x ? (wn ? wr_addr1 : wr_addr0) : (vid_req ? vid_addr : addr_q);
   assign wdata_d   = any_x ? (wn ? wr_data1 : wr_data0) : wdata_q;
   assign fb_addr   = addr_q;
   assign fb_we     = we_q;
   assign fb_wdata  = wdata_q;
   assign vid_rdata = fb_rdata;
   assign vid_valid = vid_pipe_q[RD_LAT];
   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      cnt_d   = cnt_q;
      if (state_q == IDLE) begin
         if (any_x) begin
            rr_d = ~wn;
            if (!last && BURST_MAX > 1) begin
               state_d = wn ? LOCK1 : LOCK0;
               cnt_d   = 8'd1;
            end
         end
      end else if (any_x) begin
         cnt_d = cnt_q + 8'd1;
         if (last || cnt_d == 8'(BURST_MAX)) begin
            state_d = IDLE;
            rr_d    = ~wn;
            cnt_d   = '0;
         end
      end else if (!wr_req[state_q == LOCK1]) begin
         state_d = IDLE;
         cnt_d   = '0;
      end
   end
   always_ff @(posedge clk_vga or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rr_q       <= 1'b0;
         cnt_q      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         vid_pipe_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_q       <= rr_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         we_q       <= any_x;
         vid_pipe_q <= (RD_LAT+1)'({vid_pipe_q, vid_req});
      end
   end
`ifdef FB_ARB_STATS_EN
   logic stall;
   assign stall = |wr_req && wr_gnt == 2'b00;
   always_ff @(posedge clk_vga or negedge rst_n) begin
      if (!rst_n) begin
         stat_wr_cnt    <= '0;
         stat_stall_cnt <= '0;
      end else begin
         stat_wr_cnt    <= stat_wr_cnt + {31'd0, any_x && ~&stat_wr_cnt};
         stat_stall_cnt <= stat_stall_cnt + {31'd0, stall && ~&stat_stall_cnt};
      end
   end
`endif
endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter: directed plan scenarios plus random traffic, checked
// against a transaction-level model of the arbitration rules.
module tb_fb_port_arbiter;
   import fb_pkg::*;
   localparam int AW = FB_ADDR_W;
   localparam int DW = FB_DATA_W;
   localparam int RL = 1;
   localparam int BM = 16;
   logic          clk = 1'b0, rst_n = 1'b0, vid_req = 1'b0;
   logic [AW-1:0] vid_addr = '0, wr_addr0 = '0, wr_addr1 = '0, fb_addr;
   logic [DW-1:0] wr_data0 = '0, wr_data1 = '0, fb_rdata = '0, vid_rdata, fb_wdata;
   logic [1:0]    wr_req = '0, wr_last = '0, wr_gnt;
   logic          vid_valid, fb_we;
`ifdef FB_ARB_STATS_EN
   logic [31:0]   stat_wr_cnt, stat_stall_cnt;
`endif
   always #5 clk = ~clk;
   fb_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .BURST_MAX(BM)) dut (
      .clk_vga(clk), .rst_n(rst_n), .vid_req(vid_req), .vid_addr(vid_addr),
      .vid_rdata(vid_rdata), .vid_valid(vid_valid), .wr_req(wr_req),
      .wr_addr0(wr_addr0), .wr_addr1(wr_addr1), .wr_data0(wr_data0), .wr_data1(wr_data1),
      .wr_last(wr_last), .wr_gnt(wr_gnt), .fb_addr(fb_addr), .fb_we(fb_we),
      .fb_wdata(fb_wdata), .fb_rdata(fb_rdata)
`ifdef FB_ARB_STATS_EN
      , .stat_wr_cnt(stat_wr_cnt), .stat_stall_cnt(stat_stall_cnt)
`endif
   );
   int n_cmp = 0, n_err = 0;
   int owner, beats, rr, m_wr, m_stall, run, beat;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_data;
   logic          e_we;
   logic [RL:0]   vhist;
   logic [1:0]    e_gnt, obs_gnt, last_x;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic model_reset();
      owner = -1; beats = 0; rr = 0; m_wr = 0; m_stall = 0;
      e_addr = '0; e_data = '0; e_we = 1'b0; vhist = '0; last_x = '0;
   endtask
   function automatic logic [1:0] model_gnt();
      if (vid_req) return 2'b00;
      if (owner >= 0) return wr_req[owner] ? 2'(1 << owner) : 2'b00;
      if (wr_req == 2'b11) return 2'(1 << rr);
      return wr_req;
   endfunction
   // Called at a falling edge with inputs already driven; advances one clock.
   task automatic step();
      int n;
      #1;
      e_gnt   = model_gnt();
      obs_gnt = wr_gnt;
      chk("wr_gnt", wr_gnt, e_gnt);
      chk("fb_addr", fb_addr, e_addr);
      chk("fb_we", fb_we, e_we);
      chk("fb_wdata", fb_wdata, e_data);
      chk("vid_valid", vid_valid, vhist[RL]);
      chk("vid_rdata", vid_rdata, fb_rdata);
`ifdef FB_ARB_STATS_EN
      chk("stat_wr", stat_wr_cnt, m_wr);
      chk("stat_stall", stat_stall_cnt, m_stall);
`endif
      last_x = wr_req & e_gnt;
      @(posedge clk);
      n = last_x[1] ? 1 : 0;
      if (last_x != 2'b00) begin
         e_we = 1'b1; m_wr++;
         e_addr = n ? wr_addr1 : wr_addr0;
         e_data = n ? wr_data1 : wr_data0;
         if (owner < 0) begin
            rr = 1 - n;
            if (!wr_last[n] && BM > 1) begin owner = n; beats = 1; end
         end else begin
            beats++;
            if (wr_last[n] || beats == BM) begin owner = -1; rr = 1 - n; end
         end
      end else begin
         e_we = 1'b0;
         if (vid_req) e_addr = vid_addr;
         if (owner >= 0 && !wr_req[owner]) owner = -1;
      end
      if (|wr_req && e_gnt == 2'b00) m_stall++;
      vhist = {vhist[RL-1:0], vid_req};
      @(negedge clk);
   endtask
   task automatic refresh();
      if (last_x[0]) begin wr_addr0 = AW'($urandom); wr_data0 = DW'($urandom); end
      if (last_x[1]) begin wr_addr1 = AW'($urandom); wr_data1 = DW'($urandom); end
   endtask
   task automatic reset_check();
      vid_req = 1'b0; wr_req = 2'b01; wr_last = 2'b01;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_gnt", wr_gnt, 2'b00);
      chk("rst_addr", fb_addr, '0);
      chk("rst_we", fb_we, 1'b0);
      chk("rst_wdata", fb_wdata, '0);
      chk("rst_vvalid", vid_valid, 1'b0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      step();
      chk("post_rst_gnt", obs_gnt, 2'b01);
   endtask
   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      // Video owns the port while writers wait.
      wr_req = 2'b11; wr_last = 2'b11; vid_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         vid_addr = AW'(100 + i);
         step();
         chk("vid_blocks", obs_gnt, 2'b00);
      end
      vid_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("alternate", obs_gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
         refresh();
      end
      run = 0; beat = 1;
      for (int c = 0; c < 20; c++) begin
         wr_last = {1'b1, beat == 5};
         step(); refresh();
         if (obs_gnt == 2'b10) break;
         if (obs_gnt == 2'b01) begin run++; beat++; end
      end
      chk("burst5_run", run, 5);
      chk("burst5_next", obs_gnt, 2'b10);
      run = 0; wr_last = 2'b10;
      for (int c = 0; c < 40; c++) begin
         step(); refresh();
         if (obs_gnt == 2'b10) break;
         if (obs_gnt == 2'b01) run++;
      end
      chk("burst_max_run", run, BM);
      chk("burst_max_next", obs_gnt, 2'b10);
      step(); refresh();
      step(); refresh();
      vid_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         vid_addr = AW'(200 + i);
         step();
         chk("pause_gnt", obs_gnt, 2'b00);
      end
      vid_req = 1'b0;
      step(); refresh();
      chk("resume_b3", obs_gnt, 2'b01);
      wr_last = 2'b11;
      step(); refresh();
      for (int c = 0; c < 800; c++) begin
         if (c == 400) reset_check();
         for (int n = 0; n < 2; n++)
            if (!wr_req[n] || last_x[n]) begin
               wr_req[n]  = $urandom_range(0, 3) != 0;
               wr_last[n] = $urandom_range(0, 7) == 0;
               if (n == 0) begin wr_addr0 = AW'($urandom); wr_data0 = DW'($urandom); end
               else begin wr_addr1 = AW'($urandom); wr_data1 = DW'($urandom); end
            end
         vid_req  = $urandom_range(0, 2) == 0;
         vid_addr = AW'($urandom);
         fb_rdata = DW'($urandom);
         step();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
